// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the sliding-window generator family.
package cnn_pkg;

    localparam int unsigned K_SMALL    = 3;
    localparam int unsigned K_LARGE    = 5;
    localparam int unsigned STRIDE_ONE = 1;
    localparam int unsigned STRIDE_TWO = 2;

    function automatic logic is_legal_k(input int unsigned k);
        return (k == K_SMALL) || (k == K_LARGE);
    endfunction

    function automatic logic is_legal_stride(input int unsigned s);
        return (s == STRIDE_ONE) || (s == STRIDE_TWO);
    endfunction

    // Flattened window slot for a tap at (row, col), row-major.
    function automatic int unsigned slot_index(input int unsigned row,
                                               input int unsigned col,
                                               input int unsigned k);
        return row * k + col;
    endfunction

    // Last row/column index at which a stride-aligned window ends.
    function automatic int unsigned last_aligned(input int unsigned dim,
                                                 input int unsigned k,
                                                 input int unsigned s);
        return (k - 1) + ((dim - k) / s) * s;
    endfunction

endpackage

// File: rtl/window_gen_kxk_if.sv
// Pixel-in / window-out stream bundle for window_gen_kxk.
interface window_gen_kxk_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned K          = 3
) ();

    logic                      data_valid_in;
    logic [DATA_WIDTH-1:0]     data_in;
    logic [K*K*DATA_WIDTH-1:0] window_out;
    logic                      valid_out;
    logic                      frame_done;

    // Window generator side.
    modport slave (
        input  data_valid_in,
        input  data_in,
        output window_out,
        output valid_out,
        output frame_done
    );

    // Pixel source / window consumer side.
    modport master (
        output data_valid_in,
        output data_in,
        input  window_out,
        input  valid_out,
        input  frame_done
    );

endinterface

// File: rtl/window_gen_kxk_row_delay.sv
// One image-row delay line: output is the pixel accepted DEPTH accepts ago.
// Contents are not reset; consumers gate on row/column position instead.
module row_delay #(
    parameter int unsigned DEPTH = 34,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Shift one position per accepted pixel.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/window_gen_kxk.sv
// KxK sliding-window generator over a raster pixel stream with stride
// 1 or 2. Emits one registered window per stride-aligned pixel.
module window_gen_kxk
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_WIDTH  = 34,
    parameter int unsigned IMG_HEIGHT = 34,
    parameter int unsigned K          = 3,
    parameter int unsigned STRIDE     = 1
) (
    input logic               clk,
    input logic               resetn,
    window_gen_kxk_if.slave   bus
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_MAX     = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_FIRST   = CW'(K - 1);
    localparam logic [CW-1:0] COL_LAST_AL = CW'(last_aligned(IMG_WIDTH, K, STRIDE));
    localparam logic [RW-1:0] ROW_MAX     = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FIRST   = RW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST_AL = RW'(last_aligned(IMG_HEIGHT, K, STRIDE));
    localparam logic          PH_MAX      = 1'(STRIDE - 1);

    // Elaboration-time parameter legality.
    if (!is_legal_k(K)) begin : g_bad_k
        $error("window_gen_kxk: K must be 3 or 5");
    end
    if (!is_legal_stride(STRIDE)) begin : g_bad_stride
        $error("window_gen_kxk: STRIDE must be 1 or 2");
    end
    if (IMG_WIDTH < K) begin : g_bad_width
        $error("window_gen_kxk: IMG_WIDTH must be at least K");
    end
    if (IMG_HEIGHT < K) begin : g_bad_height
        $error("window_gen_kxk: IMG_HEIGHT must be at least K");
    end

    function automatic logic ph_step(input logic ph);
        return (ph == PH_MAX) ? 1'b0 : ph + 1'b1;
    endfunction

    logic                      accept;
    logic                      emit;
    logic                      frame_end;
    logic [CW-1:0]             col;
    logic [RW-1:0]             row;
    logic                      col_ph;
    logic                      row_ph;

    logic [DATA_WIDTH-1:0]     dly_in  [K-1];
    logic [DATA_WIDTH-1:0]     dly_out [K-1];
    logic [DATA_WIDTH-1:0]     row_in  [K];
    logic [DATA_WIDTH-1:0]     taps     [K][K];
    logic [DATA_WIDTH-1:0]     tap_next [K][K];
    logic [K*K*DATA_WIDTH-1:0] win_flat;

    logic                      valid_q;
    logic                      frame_done_q;
    logic [K*K*DATA_WIDTH-1:0] window_q;

    assign accept = bus.data_valid_in;

    // Chain of K-1 row delays; delay i yields the pixel (i+1) rows above.
    for (genvar i = 0; i < K - 1; i++) begin : g_row_delay
        if (i == 0) begin : g_head
            assign dly_in[i] = bus.data_in;
        end else begin : g_link
            assign dly_in[i] = dly_out[i-1];
        end
        row_delay #(
            .DEPTH (IMG_WIDTH),
            .WIDTH (DATA_WIDTH)
        ) u_row_delay (
            .clk  (clk),
            .en   (accept),
            .din  (dly_in[i]),
            .dout (dly_out[i])
        );
    end

    // Tap row 0 is the oldest image row, tap row K-1 is the live pixel.
    for (genvar j = 0; j < K; j++) begin : g_row_in
        if (j == K - 1) begin : g_live
            assign row_in[j] = bus.data_in;
        end else begin : g_delayed
            assign row_in[j] = dly_out[K-2-j];
        end
    end

    // Position and stride-phase tracking of the pixel about to be accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col    <= '0;
            row    <= '0;
            col_ph <= 1'b0;
            row_ph <= 1'b0;
        end else if (accept) begin
            if (col == COL_MAX) begin
                col    <= '0;
                col_ph <= 1'b0;
                if (row == ROW_MAX) begin
                    row    <= '0;
                    row_ph <= 1'b0;
                end else begin
                    row    <= row + 1'b1;
                    row_ph <= (row >= ROW_FIRST) ? ph_step(row_ph) : 1'b0;
                end
            end else begin
                col    <= col + 1'b1;
                col_ph <= (col >= COL_FIRST) ? ph_step(col_ph) : 1'b0;
            end
        end
    end

    assign emit = accept && (row >= ROW_FIRST) && (col >= COL_FIRST)
                  && (col_ph == 1'b0) && (row_ph == 1'b0);
    assign frame_end = emit && (row == ROW_LAST_AL) && (col == COL_LAST_AL);

    // Next tap contents: every row shifts left and takes its row source.
    always_comb begin
        for (int unsigned j = 0; j < K; j++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
                tap_next[j][c] = taps[j][c+1];
            end
            tap_next[j][K-1] = row_in[j];
        end
    end

    // Flatten the post-accept taps into slot order.
    always_comb begin
        win_flat = '0;
        for (int unsigned j = 0; j < K; j++) begin
            for (int unsigned c = 0; c < K; c++) begin
                win_flat[slot_index(j, c, K)*DATA_WIDTH +: DATA_WIDTH] = tap_next[j][c];
            end
        end
    end

    // Tap register array advances only on accepted pixels.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned j = 0; j < K; j++) begin
                for (int unsigned c = 0; c < K; c++) begin
                    taps[j][c] <= '0;
                end
            end
        end else if (accept) begin
            taps <= tap_next;
        end
    end

    // Output register: window captured from the same edge that accepts
    // the qualifying pixel, held until the next aligned pixel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            window_q     <= '0;
        end else begin
            valid_q      <= emit;
            frame_done_q <= frame_end;
            if (emit) begin
                window_q <= win_flat;
            end
        end
    end

    assign bus.valid_out  = valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.window_out = window_q;

endmodule

// File: tb/tb_window_gen_kxk.sv
// Directed scoreboard bench for window_gen_kxk: three geometries
// (3x3 s1, 3x3 s2, 5x5 s1), gaps, back-to-back frames, mid-frame reset.
module tb_window_gen_kxk;

    localparam int unsigned DW   = 32;
    localparam int unsigned PADW = 800;

    typedef struct {
        logic [PADW-1:0] win;
        logic            fd;
        int              cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    exp_t            q0[$];
    exp_t            q1[$];
    exp_t            q2[$];
    logic [PADW-1:0] last_exp [3];
    int              win_cnt  [3];
    int              fd_cnt   [3];

    window_gen_kxk_if #(.DATA_WIDTH(DW), .K(3)) ifa ();
    window_gen_kxk_if #(.DATA_WIDTH(DW), .K(3)) ifb ();
    window_gen_kxk_if #(.DATA_WIDTH(DW), .K(5)) ifc ();

    window_gen_kxk #(.DATA_WIDTH(DW), .IMG_WIDTH(5), .IMG_HEIGHT(4), .K(3), .STRIDE(1))
        dut_a (.clk(clk), .resetn(rst_n), .bus(ifa));
    window_gen_kxk #(.DATA_WIDTH(DW), .IMG_WIDTH(5), .IMG_HEIGHT(4), .K(3), .STRIDE(2))
        dut_b (.clk(clk), .resetn(rst_n), .bus(ifb));
    window_gen_kxk #(.DATA_WIDTH(DW), .IMG_WIDTH(6), .IMG_HEIGHT(6), .K(5), .STRIDE(1))
        dut_c (.clk(clk), .resetn(rst_n), .bus(ifc));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void geom(input int unsigned which, output int unsigned k,
                                 output int unsigned w, output int unsigned h,
                                 output int unsigned s);
        case (which)
            0:       begin k = 3; w = 5; h = 4; s = 1; end
            1:       begin k = 3; w = 5; h = 4; s = 2; end
            default: begin k = 5; w = 6; h = 6; s = 1; end
        endcase
    endfunction

    function automatic int qsize(input int unsigned which);
        case (which)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int unsigned which, input exp_t e);
        case (which)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop(input int unsigned which, output exp_t e);
        case (which)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic set_in(input int unsigned which, input logic v, input logic [DW-1:0] d);
        case (which)
            0:       begin ifa.data_valid_in = v; ifa.data_in = d; end
            1:       begin ifb.data_valid_in = v; ifb.data_in = d; end
            default: begin ifc.data_valid_in = v; ifc.data_in = d; end
        endcase
    endtask

    // Output monitor: scoreboard pop on valid, hold/quiet checks otherwise.
    task automatic mon(input int unsigned which, input logic v, input logic fd,
                       input logic [PADW-1:0] win);
        exp_t e;
        if (v === 1'b1) begin
            checks++;
            assert (qsize(which) != 0) else begin
                errors++;
                $error("FAIL dut%0d_unexpected_valid observed valid=1 expected valid=0", which);
            end
            if (qsize(which) != 0) begin
                pop(which, e);
                checks++;
                assert (win === e.win) else begin
                    errors++;
                    $error("FAIL dut%0d_window observed=%h expected=%h", which, win, e.win);
                end
                checks++;
                assert (fd === e.fd) else begin
                    errors++;
                    $error("FAIL dut%0d_frame_done observed=%b expected=%b", which, fd, e.fd);
                end
                checks++;
                assert (cyc === e.cyc) else begin
                    errors++;
                    $error("FAIL dut%0d_latency observed cycle=%0d expected cycle=%0d", which, cyc, e.cyc);
                end
                last_exp[which] = e.win;
                win_cnt[which]++;
                if (fd === 1'b1) fd_cnt[which]++;
            end
        end else begin
            checks++;
            assert (v === 1'b0 && fd === 1'b0) else begin
                errors++;
                $error("FAIL dut%0d_idle_flags observed valid=%b fd=%b expected valid=0 fd=0", which, v, fd);
            end
            checks++;
            assert (win === last_exp[which]) else begin
                errors++;
                $error("FAIL dut%0d_hold observed=%h expected=%h", which, win, last_exp[which]);
            end
        end
    endtask

    always @(negedge clk) mon(0, ifa.valid_out, ifa.frame_done, {512'b0, ifa.window_out});
    always @(negedge clk) mon(1, ifb.valid_out, ifb.frame_done, {512'b0, ifb.window_out});
    always @(negedge clk) mon(2, ifc.valid_out, ifc.frame_done, ifc.window_out);

    // Drive npix raster pixels base+p, with optional random idle gaps,
    // pushing the expected window for every aligned pixel.
    task automatic run_frame(input int unsigned which, input int unsigned base,
                             input int unsigned max_gap, input int unsigned npix);
        int unsigned k, w, h, s, r, c, gap;
        exp_t e;
        geom(which, k, w, h, s);
        for (int unsigned p = 0; p < npix; p++) begin
            gap = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
            repeat (gap) begin
                @(posedge clk); #1;
                set_in(which, 1'b0, $urandom);
            end
            @(posedge clk); #1;
            set_in(which, 1'b1, base + p);
            r = p / w;
            c = p % w;
            if (r >= k - 1 && c >= k - 1 && (r - (k - 1)) % s == 0 && (c - (k - 1)) % s == 0) begin
                e.win = '0;
                for (int unsigned j = 0; j < k; j++) begin
                    for (int unsigned kk = 0; kk < k; kk++) begin
                        e.win[(j * k + kk) * DW +: DW] = base + (r - k + 1 + j) * w + (c - k + 1 + kk);
                    end
                end
                e.fd  = (r + s > h - 1) && (c + s > w - 1);
                e.cyc = cyc + 1;
                push(which, e);
            end
        end
    endtask

    task automatic idle(input int unsigned which);
        @(posedge clk); #1;
        set_in(which, 1'b0, '0);
    endtask

    task automatic start_phase(input int unsigned which);
        win_cnt[which] = 0;
        fd_cnt[which]  = 0;
    endtask

    // Wait (bounded) for all expected windows, then check totals.
    task automatic drain(input int unsigned which, input int unsigned frames, input string tag);
        int unsigned k, w, h, s;
        int n;
        int exp_win;
        geom(which, k, w, h, s);
        exp_win = int'(frames * (((h - k) / s + 1) * ((w - k) / s + 1)));
        n = 0;
        idle(which);
        while (qsize(which) != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk); #1;
        checks++;
        assert (qsize(which) == 0) else begin
            errors++;
            $error("FAIL %s_drain observed pending=%0d expected pending=0", tag, qsize(which));
        end
        checks++;
        assert (win_cnt[which] == exp_win) else begin
            errors++;
            $error("FAIL %s_window_count observed=%0d expected=%0d", tag, win_cnt[which], exp_win);
        end
        checks++;
        assert (fd_cnt[which] == int'(frames)) else begin
            errors++;
            $error("FAIL %s_frame_done_count observed=%0d expected=%0d", tag, fd_cnt[which], frames);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        checks++;
        assert ({ifa.valid_out, ifa.frame_done, ifb.valid_out, ifb.frame_done,
                 ifc.valid_out, ifc.frame_done} === 6'b0) else begin
            errors++;
            $error("FAIL %s_flags observed=%b%b%b%b%b%b expected=000000", tag,
                   ifa.valid_out, ifa.frame_done, ifb.valid_out, ifb.frame_done,
                   ifc.valid_out, ifc.frame_done);
        end
        checks++;
        assert (ifa.window_out === '0) else begin
            errors++; $error("FAIL %s_win_a observed=%h expected=0", tag, ifa.window_out);
        end
        checks++;
        assert (ifb.window_out === '0) else begin
            errors++; $error("FAIL %s_win_b observed=%h expected=0", tag, ifb.window_out);
        end
        checks++;
        assert (ifc.window_out === '0) else begin
            errors++; $error("FAIL %s_win_c observed=%h expected=0", tag, ifc.window_out);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            last_exp[i] = '0;
            win_cnt[i]  = 0;
            fd_cnt[i]   = 0;
            set_in(i, 1'b0, '0);
        end
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 3x3 stride 1, contiguous pixels 0..19.
        start_phase(0);
        run_frame(0, 0, 0, 20);
        drain(0, 1, "k3s1");

        // 3x3 stride 2, same frame.
        start_phase(1);
        run_frame(1, 0, 0, 20);
        drain(1, 1, "k3s2");

        // 3x3 stride 1 with random idle gaps of 0..3 cycles.
        start_phase(0);
        run_frame(0, 0, 3, 20);
        drain(0, 1, "k3s1_gaps");

        // Two back-to-back frames, second one valued 100..119.
        start_phase(0);
        run_frame(0, 0, 0, 20);
        run_frame(0, 100, 0, 20);
        drain(0, 2, "k3s1_b2b");

        // Reset after pixel 7 (inputs kept active during reset), then a full frame.
        start_phase(0);
        run_frame(0, 0, 0, 8);
        idle(0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) last_exp[i] = '0;
        #1;
        chk_zero("midreset");
        repeat (3) begin
            @(posedge clk); #1;
            set_in(0, 1'b1, $urandom);
            chk_zero("midreset_hold");
        end
        set_in(0, 1'b0, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_frame(0, 0, 0, 20);
        drain(0, 1, "k3s1_after_reset");

        // 5x5 stride 1 on a 6x6 frame.
        start_phase(2);
        run_frame(2, 0, 0, 36);
        drain(2, 1, "k5s1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
